// File: rtl/tx_frame_builder.sv
// tx_frame_builder
//   Transmit-side framer for the GTX serial link. Every cycle out of reset one
//   frame {header, payload} is launched into the registered o_tx_frame.
//   After reset or a retrain pulse a burst of TRAIN_LEN training frames is
//   sent so the far-end sync controller can lock. After that, user words are
//   streamed through a valid/ready handshake, and idle frames fill the gaps.
//   i_inject_err flips the header of the frame launched that cycle to 2'b10.
//
//   state | meaning
//   TRAIN | sending TRAIN_LEN training frames, no user data accepted
//   RUN   | streaming user data, idle frames when nothing is transferred
//
// Ports:
//   i_clk          TX user clock, rising edge
//   i_rst          synchronous reset, active high
//   i_data_in      user payload
//   i_data_valid   i_data_in is valid
//   o_data_ready   builder accepts i_data_in this cycle
//   i_retrain      one-cycle pulse, restart the training burst
//   i_inject_err   corrupt the header of the frame launched this cycle
//   o_tx_frame     {header, payload}, registered
//   o_tx_is_data   o_tx_frame holds user data, registered
//   o_tx_state     2'b00 TRAIN, 2'b10 RUN
//   o_frame_cnt    frames launched since reset, wraps
module tx_frame_builder #(
  parameter int                 DATA_W     = 32,
  parameter int                 TRAIN_LEN  = 64,
  parameter logic [DATA_W-1:0]  TRAIN_WORD = 32'hA5A5_A5A5,
  parameter logic [DATA_W-1:0]  IDLE_WORD  = 32'hBC5A_5ABC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  input  logic              i_retrain,
  input  logic              i_inject_err,
  output logic [DATA_W+1:0] o_tx_frame,
  output logic              o_tx_is_data,
  output logic [1:0]        o_tx_state,
  output logic [15:0]       o_frame_cnt
);

  localparam int CNT_W = $clog2(TRAIN_LEN);
  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);

  typedef enum logic [1:0] {
    TRAIN = 2'b00,
    RUN   = 2'b10
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_train_cnt;
  logic [DATA_W+1:0] r_tx_frame;
  logic              r_tx_is_data;
  logic [15:0]       r_frame_cnt;

  logic              w_ready;
  logic              w_xfer;
  logic [1:0]        w_header;

  // Ready is held low during a retrain cycle so the word stays upstream and
  // goes out first once RUN resumes.
  assign w_ready  = !i_rst && (r_state == RUN) && !i_retrain;
  assign w_xfer   = w_ready && i_data_valid;
  assign w_header = i_inject_err ? 2'b10 : 2'b01;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= TRAIN;
      r_train_cnt  <= '0;
      r_tx_frame   <= '0;
      r_tx_is_data <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
      case (r_state)
        TRAIN: begin
          r_tx_frame   <= {w_header, TRAIN_WORD};
          r_tx_is_data <= 1'b0;
          if (r_train_cnt == TRAIN_LAST) begin
            r_state     <= RUN;
            r_train_cnt <= '0;
          end else begin
            r_train_cnt <= r_train_cnt + 1'b1;
          end
        end
        RUN: begin
          if (w_xfer) begin
            r_tx_frame   <= {w_header, i_data_in};
            r_tx_is_data <= 1'b1;
          end else begin
            r_tx_frame   <= {w_header, IDLE_WORD};
            r_tx_is_data <= 1'b0;
          end
        end
        default: begin
          r_state      <= TRAIN;
          r_train_cnt  <= '0;
          r_tx_frame   <= {w_header, TRAIN_WORD};
          r_tx_is_data <= 1'b0;
        end
      endcase
      // Frame for this cycle is already chosen above; retrain only redirects
      // the next state, restarting the burst from frame 0.
      if (i_retrain) begin
        r_state     <= TRAIN;
        r_train_cnt <= '0;
      end
    end
  end

  assign o_data_ready = w_ready;
  assign o_tx_frame   = r_tx_frame;
  assign o_tx_is_data = r_tx_is_data;
  assign o_tx_state   = r_state;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder: training burst, data streaming with a
// gap, header corruption, retrain from RUN and mid-burst, reset mid-burst,
// and frame counter wrap.
module tb_tx_frame_builder;

  localparam logic [33:0] F_TRAIN = 34'h1_A5A5A5A5;
  localparam logic [33:0] F_IDLE  = 34'h1_BC5A5ABC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        retrain = 1'b0;
  logic        inject_err = 1'b0;
  logic [33:0] tx_frame;
  logic        tx_is_data;
  logic [1:0]  tx_state;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int ntrain;

  tx_frame_builder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_in    (data_in),
    .i_data_valid (data_valid),
    .o_data_ready (data_ready),
    .i_retrain    (retrain),
    .i_inject_err (inject_err),
    .o_tx_frame   (tx_frame),
    .o_tx_is_data (tx_is_data),
    .o_tx_state   (tx_state),
    .o_frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count consecutive training frames until an idle frame appears, bounded.
  task automatic count_train(input int retrain_at, output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      retrain = (i == retrain_at);
      step();
      retrain = 1'b0;
      if (tx_frame === F_TRAIN) n++;
      else break;
    end
  endtask

  initial begin
    // reset
    step();
    step();
    check("rst_frame", 64'(tx_frame), 64'h0);
    check("rst_is_data", 64'(tx_is_data), 64'h0);
    check("rst_cnt", 64'(frame_cnt), 64'h0);
    check("rst_state", 64'(tx_state), 64'h0);
    check("rst_ready", 64'(data_ready), 64'h0);
    rst = 1'b0;

    // training burst of 64 frames
    for (int i = 0; i < 64; i++) begin
      #1;
      check("train_ready", 64'(data_ready), 64'h0);
      step();
      check("train_frame", 64'(tx_frame), 64'(F_TRAIN));
    end
    check("train_is_data", 64'(tx_is_data), 64'h0);
    check("run_state", 64'(tx_state), 64'h2);
    check("run_ready", 64'(data_ready), 64'h1);
    step();
    check("first_idle", 64'(tx_frame), 64'(F_IDLE));
    check("cnt_65", 64'(frame_cnt), 64'd65);

    // data with one gap
    data_valid = 1'b1; data_in = 32'h1;
    step();
    check("d1", 64'(tx_frame), 64'h1_00000001);
    check("d1_is", 64'(tx_is_data), 64'h1);
    data_in = 32'h2;
    step();
    check("d2", 64'(tx_frame), 64'h1_00000002);
    data_valid = 1'b0;
    step();
    check("gap", 64'(tx_frame), 64'(F_IDLE));
    check("gap_is", 64'(tx_is_data), 64'h0);
    data_valid = 1'b1; data_in = 32'h3;
    step();
    check("d3", 64'(tx_frame), 64'h1_00000003);
    data_in = 32'h4;
    step();
    check("d4", 64'(tx_frame), 64'h1_00000004);
    check("d4_is", 64'(tx_is_data), 64'h1);

    // header corruption
    data_in = 32'hDEADBEEF; inject_err = 1'b1;
    step();
    check("inj_frame", 64'(tx_frame), 64'h2_DEADBEEF);
    check("inj_is", 64'(tx_is_data), 64'h1);
    inject_err = 1'b0; data_valid = 1'b0;
    step();
    check("post_inj", 64'(tx_frame), 64'(F_IDLE));

    // retrain from RUN while data is held
    data_valid = 1'b1; data_in = 32'h12345678; retrain = 1'b1;
    #1;
    check("rt_ready", 64'(data_ready), 64'h0);
    step();
    retrain = 1'b0;
    check("rt_idle", 64'(tx_frame), 64'(F_IDLE));
    check("rt_is", 64'(tx_is_data), 64'h0);
    check("rt_state", 64'(tx_state), 64'h0);
    for (int i = 0; i < 64; i++) begin
      step();
      check("rt_train", 64'(tx_frame), 64'(F_TRAIN));
    end
    step();
    check("rt_held", 64'(tx_frame), 64'h1_12345678);
    check("rt_held_is", 64'(tx_is_data), 64'h1);
    data_valid = 1'b0;

    // retrain at training frame 30
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    count_train(30, ntrain);
    check("rt30_len", 64'(ntrain), 64'd95);

    // reset at training frame 10
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("pre_rst_frame", 64'(tx_frame), 64'(F_TRAIN));
    rst = 1'b1;
    step();
    check("mid_rst_cnt", 64'(frame_cnt), 64'h0);
    check("mid_rst_frame", 64'(tx_frame), 64'h0);
    rst = 1'b0;
    count_train(-1, ntrain);
    check("rst10_len", 64'(ntrain), 64'd64);
    check("rst10_idle", 64'(tx_frame), 64'(F_IDLE));
    check("rst10_cnt", 64'(frame_cnt), 64'd65);

    // counter wrap
    for (int i = 0; i < 65535 - 65; i++) step();
    check("cnt_ffff", 64'(frame_cnt), 64'hFFFF);
    step();
    check("cnt_wrap", 64'(frame_cnt), 64'h0);
    check("wrap_frame", 64'(tx_frame), 64'(F_IDLE));
    check("wrap_state", 64'(tx_state), 64'h2);
    data_valid = 1'b1; data_in = 32'hCAFE0001;
    step();
    check("wrap_data", 64'(tx_frame), 64'h1_CAFE0001);
    check("cnt_one", 64'(frame_cnt), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
